mips_multicycle_ctrl: RTL
=========================

# mips_multicycle_ctrl

Parametrised multicycle MIPS control unit: next generation of the processor's main control FSM. Sequences fetch, decode, execute, memory and write-back for R-type (add/sub/and/xor/nop/break), beq, bne, lw, sw, lui and j. Supports a configurable number of memory wait states and a halt state, and has optional overflow/illegal-instruction exceptions. Sits beside the datapath: it drives mux selects and register load strobes, and reads Op/Funct from IR plus the ALU flags.

## Interface
- MEM_WAIT, 2: extra wait cycles per memory access (0..15); 0 = single-cycle memory
- STATE_W, 8: width of StateOut
- EXC_VECTOR_SEL, 2'b11: PCSource code used for the exception vector
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Op  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- ALU_zero, ALU_overflow  in  1 each  ALU flags (combinational from datapath)
- StateOut  out  STATE_W  current state code (combinational copy of state register)
- PC_load, IRWrite, wr, RegWrite, A_load, B_load, MDR_load, ALUOut_load, EPC_load  out  1 each  strobes, active-high
- IorD, ALUSrcA, RegDst  out  1 each  mux selects
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 imm<<16
- ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector
- Halted  out  1  high in HALT

## Operation
- State codes: FETCH 0x00, FETCH_WAIT 0x01, IR_LOAD 0x02, DECODE 0x03, R_EXEC 0x04, R_WB 0x05, BRANCH 0x06, MEM_ADDR 0x07, MEM_RD 0x08, MEM_WB 0x09, MEM_WR 0x0A, LUI_WB 0x0B, JUMP 0x0C, HALT 0x0D, EXCEPT 0x0E.
- Outputs are a Moore decode of the state. Any strobe or select not listed for a state is 0.
- FETCH/FETCH_WAIT: IorD=0, wr=0. A wait counter ($clog2(MEM_WAIT+1) bits) loads MEM_WAIT in FETCH and decrements in FETCH_WAIT. FETCH_WAIT is skipped when MEM_WAIT=0.
- IR_LOAD: IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PC_load=1 (PC+4).
- DECODE: A_load=B_load=ALUOut_load=1, ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target).
- DECODE dispatch:
  - Op 0x00 with Funct 0x20/0x22/0x24/0x26 -> R_EXEC
  - Funct 0x00 -> FETCH (nop)
  - Funct 0x0D -> HALT
  - Op 0x04/0x05 -> BRANCH
  - Op 0x23/0x2B -> MEM_ADDR
  - Op 0x0F -> LUI_WB
  - Op 0x02 -> JUMP
  - anything else -> illegal
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10, ALUOut_load=1 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=00 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PC_load = ALU_zero for Op 0x04, ~ALU_zero for Op 0x05. -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, ALUOut_load=1. -> MEM_RD (lw) or MEM_WR (sw); the wait counter loads MEM_WAIT.
- MEM_RD: IorD=1 for 1+MEM_WAIT cycles; MDR_load=1 only on the last of them -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=01 -> FETCH.
- MEM_WR: IorD=1, wr=1 for 1+MEM_WAIT cycles -> FETCH.
- LUI_WB: RegWrite=1, RegDst=0, MemtoReg=10 -> FETCH.
- JUMP: PCSource=10, PC_load=1 -> FETCH.
- HALT: Halted=1, all strobes 0; stays in HALT until Reset.
- EXCEPT: EPC_load=1, PCSource=EXC_VECTOR_SEL, PC_load=1, one cycle -> FETCH.

## Timing
- Reset low (asynchronous): state=FETCH, counter=0. Strobes, selects, Halted and StateOut are all forced 0 while Reset is low. First FETCH cycle is the first rising edge after Reset is released. Reset mid-instruction aborts it with no further strobes.
- Cycles per instruction with W=MEM_WAIT:
  - R-type 5+W
  - beq/bne, j, lui 4+W
  - lw 6+2W
  - sw 5+2W
  - nop 3+W
- Counter never wraps: it stops at 0; a state leaves its wait on the cycle the counter is 0.
- PC_load in BRANCH is combinational from ALU_zero in the same cycle.

## Configuration
- CTRL_EXCEPTION_EN defined:
  - In R_EXEC with Funct 0x20/0x22 and ALU_overflow=1, next state is EXCEPT, and R_WB (RegWrite) is never entered.
  - Illegal Op/Funct in DECODE -> EXCEPT.
- CTRL_EXCEPTION_EN undefined:
  - Overflow is ignored.
  - Illegal encodings behave as nop (DECODE -> FETCH).
  - EXCEPT is unreachable and EPC_load is tied 0.

## Test plan
- Reset low mid-MEM_WR (wr=1) -> same cycle wr=0, StateOut=0x00; after release, FETCH on the first edge.
- MEM_WAIT=2, add (Op 0x00, Funct 0x20) -> StateOut sequence 00,01,01,02,03,04,05,00; RegWrite high exactly one cycle, 7 cycles total.
- MEM_WAIT=2, lw (Op 0x23) -> 10 cycles; MDR_load high only on the 3rd MEM_RD cycle; MemtoReg=01 in MEM_WB.
- bne (Op 0x05) with ALU_zero=0 -> PC_load=1, PCSource=01 in BRANCH; repeat with ALU_zero=1 -> PC_load=0.
- Funct 0x0D -> HALT, Halted=1 held for 100 cycles with no strobes; Reset pulse -> FETCH.
- CTRL_EXCEPTION_EN, sub with ALU_overflow=1 -> 04 then 0E (EPC_load=1, PCSource=11, PC_load=1), no RegWrite; Op 0x3F -> 03,0E.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/write-back with MEM_WAIT extra cycles
// per memory access. Optional exceptions (overflow on add/sub, illegal
// encodings) are enabled by defining CTRL_EXCEPTION_EN.
// Handshake: none; the datapath obeys the strobes and selects every cycle,
// and Op/Funct/ALU flags are assumed valid whenever the FSM looks at them.
module mips_multicycle_ctrl #(
   parameter int          MEM_WAIT       = 2,
   parameter int          STATE_W        = 8,
   parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               ALU_zero,
   input  logic               ALU_overflow,
   output logic [STATE_W-1:0] StateOut,
   output logic               PC_load,
   output logic               IRWrite,
   output logic               wr,
   output logic               RegWrite,
   output logic               A_load,
   output logic               B_load,
   output logic               MDR_load,
   output logic               ALUOut_load,
   output logic               EPC_load,
   output logic               IorD,
   output logic               ALUSrcA,
   output logic               RegDst,
   output logic [1:0]         MemtoReg,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               Halted
);

   localparam int CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT);

   typedef enum logic [3:0] {
      FETCH      = 4'h0,
      FETCH_WAIT = 4'h1,
      IR_LOAD    = 4'h2,
      DECODE     = 4'h3,
      R_EXEC     = 4'h4,
      R_WB       = 4'h5,
      BRANCH     = 4'h6,
      MEM_ADDR   = 4'h7,
      MEM_RD     = 4'h8,
      MEM_WB     = 4'h9,
      MEM_WR     = 4'hA,
      LUI_WB     = 4'hB,
      JUMP       = 4'hC,
      HALT       = 4'hD,
      EXCEPT     = 4'hE
   } state_e;

`ifdef CTRL_EXCEPTION_EN
   localparam state_e ILLEGAL_NEXT = EXCEPT;
`else
   localparam state_e ILLEGAL_NEXT = FETCH;
   logic unused_ovf;
   assign unused_ovf = ALU_overflow;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_dec;
   logic             is_r_alu;
   logic             is_addsub;

   assign cnt_dec   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
   assign is_r_alu  = (Funct == 6'h20) || (Funct == 6'h22) ||
                      (Funct == 6'h24) || (Funct == 6'h26);
   assign is_addsub = (Funct == 6'h20) || (Funct == 6'h22);

   // State and wait-counter registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and wait-counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         FETCH: begin
            cnt_d   = WAIT_INIT;
            state_d = (MEM_WAIT == 0) ? IR_LOAD : FETCH_WAIT;
         end
         // FETCH is itself the first memory cycle, so the wait state covers the
         // remaining MEM_WAIT cycles and leaves as the counter reaches 0.
         FETCH_WAIT: begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) state_d = IR_LOAD;
         end
         IR_LOAD: state_d = DECODE;
         DECODE: begin
            if (Op == 6'h00) begin
               if (is_r_alu)              state_d = R_EXEC;
               else if (Funct == 6'h00)   state_d = FETCH;
               else if (Funct == 6'h0D)   state_d = HALT;
               else                       state_d = ILLEGAL_NEXT;
            end else begin
               case (Op)
                  6'h04, 6'h05: state_d = BRANCH;
                  6'h23, 6'h2B: state_d = MEM_ADDR;
                  6'h0F:        state_d = LUI_WB;
                  6'h02:        state_d = JUMP;
                  default:      state_d = ILLEGAL_NEXT;
               endcase
            end
         end
         R_EXEC: begin
            state_d = R_WB;
`ifdef CTRL_EXCEPTION_EN
            if (is_addsub && ALU_overflow) state_d = EXCEPT;
`endif
         end
         MEM_ADDR: begin
            cnt_d   = WAIT_INIT;
            state_d = (Op == 6'h2B) ? MEM_WR : MEM_RD;
         end
         MEM_RD: begin
            cnt_d = cnt_dec;
            if (cnt_q == '0) state_d = MEM_WB;
         end
         MEM_WR: begin
            cnt_d = cnt_dec;
            if (cnt_q == '0) state_d = FETCH;
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // Moore output decode; everything is held at 0 while Reset is asserted.
   always_comb begin
      StateOut    = '0;
      PC_load     = 1'b0;
      IRWrite     = 1'b0;
      wr          = 1'b0;
      RegWrite    = 1'b0;
      A_load      = 1'b0;
      B_load      = 1'b0;
      MDR_load    = 1'b0;
      ALUOut_load = 1'b0;
      EPC_load    = 1'b0;
      IorD        = 1'b0;
      ALUSrcA     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      Halted      = 1'b0;
      if (Reset) begin
         StateOut = STATE_W'(state_q);
         case (state_q)
            IR_LOAD: begin
               IRWrite = 1'b1;
               ALUSrcB = 2'b01;
               PC_load = 1'b1;
            end
            DECODE: begin
               A_load      = 1'b1;
               B_load      = 1'b1;
               ALUOut_load = 1'b1;
               ALUSrcB     = 2'b11;
            end
            R_EXEC: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b10;
               ALUOut_load = 1'b1;
            end
            R_WB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            // Branch decision follows ALU_zero combinationally in this cycle.
            BRANCH: begin
               ALUSrcA  = 1'b1;
               ALUOp    = 2'b01;
               PCSource = 2'b01;
               PC_load  = (Op == 6'h04) ? ALU_zero : ~ALU_zero;
            end
            MEM_ADDR: begin
               ALUSrcA     = 1'b1;
               ALUSrcB     = 2'b10;
               ALUOut_load = 1'b1;
            end
            MEM_RD: begin
               IorD     = 1'b1;
               MDR_load = (cnt_q == '0);
            end
            MEM_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 2'b01;
            end
            MEM_WR: begin
               IorD = 1'b1;
               wr   = 1'b1;
            end
            LUI_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 2'b10;
            end
            JUMP: begin
               PCSource = 2'b10;
               PC_load  = 1'b1;
            end
            HALT: Halted = 1'b1;
            EXCEPT: begin
`ifdef CTRL_EXCEPTION_EN
               EPC_load = 1'b1;
`endif
               PCSource = EXC_VECTOR_SEL;
               PC_load  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
